// File: rtl/tm1638_responder_if.sv
// Serial LED&KEY link between a TM1638 controller and the responder.
// The controller drives clk/stb/dio; the responder returns dio with an enable.
interface tm1638_responder_if;
    logic i_ledkey_clk;
    logic i_ledkey_stb;
    logic i_ledkey_dio;
    logic o_ledkey_dio;
    logic o_ledkey_dio_oe;

    modport master (
        output i_ledkey_clk,
        output i_ledkey_stb,
        output i_ledkey_dio,
        input  o_ledkey_dio,
        input  o_ledkey_dio_oe
    );

    modport slave (
        input  i_ledkey_clk,
        input  i_ledkey_stb,
        input  i_ledkey_dio,
        output o_ledkey_dio,
        output o_ledkey_dio_oe
    );
endinterface

// File: rtl/tm1638_responder.sv
// Device-side TM1638 responder: oversamples the serial link, decodes
// command/address/data bytes and shifts key-scan data back on DIO.
module tm1638_responder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          AUTO_INC_RESET = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    tm1638_responder_if.slave    ledkey,
    input  logic [31:0]          i_keys,
    output logic                 o_wr_en,
    output logic [3:0]           o_wr_addr,
    output logic [7:0]           o_wr_data,
    output logic                 o_display_on,
    output logic [2:0]           o_brightness,
    output logic                 o_frame_err
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WRITE,
        S_READ,
        S_IGNORE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
    logic clk_prev_q, clk_prev_d;
    logic stb_prev_q, stb_prev_d;

    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [31:0] key_q, key_d;
    logic [5:0]  rd_cnt_q, rd_cnt_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        auto_inc_q, auto_inc_d;

    logic        wr_en_q, wr_en_d;
    logic [3:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        disp_on_q, disp_on_d;
    logic [2:0]  bright_q, bright_d;
    logic        frame_err_q, frame_err_d;
    logic        dio_q, dio_d;
    logic        oe_q, oe_d;

    logic       clk_s, stb_s, dio_s;
    logic       clk_rise, clk_fall;
    logic       stb_rise, stb_fall;
    logic       byte_done;
    logic [7:0] rx_byte;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign stb_s = stb_sync_q[SYNC_STAGES-1];
    assign dio_s = dio_sync_q[SYNC_STAGES-1];

    assign clk_rise = clk_s & ~clk_prev_q;
    assign clk_fall = ~clk_s & clk_prev_q;
    assign stb_rise = stb_s & ~stb_prev_q;
    assign stb_fall = ~stb_s & stb_prev_q;

    // The byte in flight including the bit arriving on this edge
    assign rx_byte   = {dio_s, shift_q[7:1]};
    assign byte_done = clk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d     = state_q;
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ledkey.i_ledkey_clk};
        stb_sync_d  = {stb_sync_q[SYNC_STAGES-2:0], ledkey.i_ledkey_stb};
        dio_sync_d  = {dio_sync_q[SYNC_STAGES-2:0], ledkey.i_ledkey_dio};
        clk_prev_d  = clk_s;
        stb_prev_d  = stb_s;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        key_d       = key_q;
        rd_cnt_d    = rd_cnt_q;
        ptr_d       = ptr_q;
        auto_inc_d  = auto_inc_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        disp_on_d   = disp_on_q;
        bright_d    = bright_q;
        frame_err_d = 1'b0;
        dio_d       = dio_q;
        oe_d        = oe_q;

        if (stb_fall) begin
            state_d   = S_CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 8'd0;
        end else if (stb_rise) begin
            state_d     = S_IDLE;
            oe_d        = 1'b0;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'd0;
            frame_err_d = (bit_cnt_q != 3'd0);
        end else if (state_q != S_IDLE) begin
            if (clk_rise) begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            if (clk_rise && state_q != S_READ) begin
                shift_d = rx_byte;
            end

            unique case (state_q)
                S_CMD: begin
                    if (byte_done) begin
                        unique case (rx_byte[7:6])
                            2'b01: begin
                                if (rx_byte[1]) begin
                                    key_d    = i_keys;
                                    rd_cnt_d = 6'd0;
                                    state_d  = S_READ;
                                end else begin
                                    auto_inc_d = ~rx_byte[2];
                                    state_d    = S_IGNORE;
                                end
                            end
                            2'b10: begin
                                disp_on_d = rx_byte[3];
                                bright_d  = rx_byte[2:0];
                                state_d   = S_IGNORE;
                            end
                            2'b11: begin
                                ptr_d   = rx_byte[3:0];
                                state_d = S_WRITE;
                            end
                            default: state_d = S_IGNORE;
                        endcase
                    end
                end
                S_WRITE: begin
                    if (byte_done) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_byte;
                        if (auto_inc_q) begin
                            ptr_d = ptr_q + 4'd1;
                        end
                    end
                end
                S_READ: begin
                    if (clk_fall) begin
                        if (rd_cnt_q == 6'd32) begin
                            oe_d    = 1'b0;
                            state_d = S_IGNORE;
                        end else begin
                            oe_d     = 1'b1;
                            dio_d    = key_q[0];
                            key_d    = {1'b0, key_q[31:1]};
                            rd_cnt_d = rd_cnt_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobe sync resets low so a strobe held low across reset is not a new frame
    always_ff @(posedge i_clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= '0;
            stb_sync_q  <= '0;
            dio_sync_q  <= '0;
            clk_prev_q  <= 1'b0;
            stb_prev_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            key_q       <= 32'd0;
            rd_cnt_q    <= 6'd0;
            ptr_q       <= 4'd0;
            auto_inc_q  <= AUTO_INC_RESET;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'd0;
            disp_on_q   <= 1'b0;
            bright_q    <= 3'd0;
            frame_err_q <= 1'b0;
            dio_q       <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            stb_sync_q  <= stb_sync_d;
            dio_sync_q  <= dio_sync_d;
            clk_prev_q  <= clk_prev_d;
            stb_prev_q  <= stb_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            key_q       <= key_d;
            rd_cnt_q    <= rd_cnt_d;
            ptr_q       <= ptr_d;
            auto_inc_q  <= auto_inc_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            disp_on_q   <= disp_on_d;
            bright_q    <= bright_d;
            frame_err_q <= frame_err_d;
            dio_q       <= dio_d;
            oe_q        <= oe_d;
        end
    end

    assign o_wr_en                = wr_en_q;
    assign o_wr_addr              = wr_addr_q;
    assign o_wr_data              = wr_data_q;
    assign o_display_on           = disp_on_q;
    assign o_brightness           = bright_q;
    assign o_frame_err            = frame_err_q;
    assign ledkey.o_ledkey_dio    = dio_q;
    assign ledkey.o_ledkey_dio_oe = oe_q;
endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: drives TM1638 frames as a controller and
// checks writes, display state and key reads against a frame-level model.
module tb_tm1638_responder;
    localparam int HALF = 50;

    logic        i_clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_keys;
    logic        o_wr_en;
    logic [3:0]  o_wr_addr;
    logic [7:0]  o_wr_data;
    logic        o_display_on;
    logic [2:0]  o_brightness;
    logic        o_frame_err;

    tm1638_responder_if lk ();

    tm1638_responder #(
        .SYNC_STAGES    (2),
        .AUTO_INC_RESET (1'b1)
    ) dut (
        .i_clk        (i_clk),
        .rst_n        (rst_n),
        .ledkey       (lk.slave),
        .i_keys       (i_keys),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_display_on (o_display_on),
        .o_brightness (o_brightness),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    logic [11:0] got_wr[$];
    int          err_cycles = 0;
    int          wr_wide = 0;
    logic        wr_prev = 1'b0;

    // Observe the write bus and error pulse away from the active edge
    always @(negedge i_clk) begin
        if (o_wr_en) got_wr.push_back({o_wr_addr, o_wr_data});
        if (o_wr_en && wr_prev) wr_wide++;
        wr_prev = o_wr_en;
        if (o_frame_err) err_cycles++;
    end

    // Frame-level model of the device's persistent state
    logic       m_on;
    logic [2:0] m_br;
    logic       m_auto;
    logic [7:0] fb[$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        lk.i_ledkey_clk = 1'b0;
        lk.i_ledkey_dio = b;
        #HALF;
        lk.i_ledkey_clk = 1'b1;
        #HALF;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic run_frame(input string tag);
        logic [11:0] exp_wr[$];
        logic [3:0]  p;
        int          w0;
        int          e0;
        int          n;
        w0 = got_wr.size();
        e0 = err_cycles;
        lk.i_ledkey_stb = 1'b0;
        #HALF;
        foreach (fb[i]) send_byte(fb[i]);
        #HALF;
        lk.i_ledkey_stb = 1'b1;
        #(4 * HALF);

        case (fb[0][7:6])
            2'b01: if (!fb[0][1]) m_auto = !fb[0][2];
            2'b10: begin
                m_on = fb[0][3];
                m_br = fb[0][2:0];
            end
            2'b11: begin
                p = fb[0][3:0];
                for (int i = 1; i < fb.size(); i++) begin
                    exp_wr.push_back({p, fb[i]});
                    if (m_auto) p = 4'((p + 1) % 16);
                end
            end
            default: ;
        endcase

        n = got_wr.size() - w0;
        check({tag, "_nwr"}, 32'(n), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < n; i++)
            check({tag, "_wr"}, 32'(got_wr[w0 + i]), 32'(exp_wr[i]));
        check({tag, "_wide"}, 32'(wr_wide), 32'd0);
        check({tag, "_err"}, 32'(err_cycles - e0), 32'd0);
        check({tag, "_on"}, 32'(o_display_on), 32'(m_on));
        check({tag, "_br"}, 32'(o_brightness), 32'(m_br));
    endtask

    task automatic key_read(input logic [31:0] k);
        logic [31:0] cap;
        logic        oe_all;
        int          w0;
        int          e0;
        w0 = got_wr.size();
        e0 = err_cycles;
        i_keys = k;
        lk.i_ledkey_stb = 1'b0;
        #HALF;
        send_byte(8'h42);
        i_keys = ~k;
        cap = '0;
        oe_all = 1'b1;
        for (int i = 0; i < 32; i++) begin
            lk.i_ledkey_clk = 1'b0;
            #HALF;
            cap[i] = lk.o_ledkey_dio;
            oe_all = oe_all & lk.o_ledkey_dio_oe;
            lk.i_ledkey_clk = 1'b1;
            #HALF;
        end
        check("rd_data", cap, k);
        check("rd_oe_on", 32'(oe_all), 32'd1);
        lk.i_ledkey_clk = 1'b0;
        #HALF;
        check("rd_oe_end", 32'(lk.o_ledkey_dio_oe), 32'd0);
        lk.i_ledkey_stb = 1'b1;
        #HALF;
        lk.i_ledkey_clk = 1'b1;
        #(3 * HALF);
        check("rd_oe_stb", 32'(lk.o_ledkey_dio_oe), 32'd0);
        check("rd_err", 32'(err_cycles - e0), 32'd0);
        check("rd_nwr", 32'(got_wr.size() - w0), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        int          e0;
        int          w0;

        rst_n = 1'b0;
        i_keys = '0;
        lk.i_ledkey_clk = 1'b1;
        lk.i_ledkey_stb = 1'b1;
        lk.i_ledkey_dio = 1'b0;
        m_on = 1'b0;
        m_br = 3'd0;
        m_auto = 1'b1;
        #40;
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_on", 32'(o_display_on), 32'd0);
        check("rst_br", 32'(o_brightness), 32'd0);
        check("rst_err", 32'(o_frame_err), 32'd0);
        check("rst_oe", 32'(lk.o_ledkey_dio_oe), 32'd0);
        check("rst_dio", 32'(lk.o_ledkey_dio), 32'd0);
        rst_n = 1'b1;
        #100;

        fb = '{8'hC3, 8'h01, 8'h02};
        run_frame("inc_rst");

        fb = '{8'h8F};
        run_frame("disp8f");

        fb = '{8'h40};
        run_frame("mode40");
        fb = '{8'hC0, 8'h3F, 8'h06, 8'h5B};
        run_frame("autoinc");

        fb = '{8'h44};
        run_frame("mode44");
        fb = '{8'hCF, 8'hAA, 8'h55};
        run_frame("fixed");

        fb = '{8'h40};
        run_frame("mode40b");
        fb = '{8'hCF, 8'h11, 8'h22};
        run_frame("wrap");

        key_read(32'h8000_01A5);

        // Abort inside a command byte
        e0 = err_cycles;
        w0 = got_wr.size();
        lk.i_ledkey_stb = 1'b0;
        #HALF;
        for (int i = 0; i < 5; i++) send_bit(((8'hC3 >> i) & 8'h01) != 0);
        #HALF;
        lk.i_ledkey_stb = 1'b1;
        #(4 * HALF);
        check("abort_err", 32'(err_cycles - e0), 32'd1);
        check("abort_nwr", 32'(got_wr.size() - w0), 32'd0);
        fb = '{8'h8A};
        run_frame("after_abort");

        // Abort in the middle of a key read
        i_keys = 32'h1234_5678;
        e0 = err_cycles;
        lk.i_ledkey_stb = 1'b0;
        #HALF;
        send_byte(8'h42);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        check("rdab_oe_pre", 32'(lk.o_ledkey_dio_oe), 32'd1);
        lk.i_ledkey_stb = 1'b1;
        #30;
        check("rdab_oe", 32'(lk.o_ledkey_dio_oe), 32'd0);
        #(3 * HALF);
        check("rdab_err", 32'(err_cycles - e0), 32'd1);

        for (int it = 0; it < 24; it++) begin
            r = $urandom;
            fb.delete();
            case (r[31:29])
                3'd0, 3'd1: fb.push_back(8'h80 | (r[7:0] & 8'h3F));
                3'd2: fb.push_back(8'h40 | (r[7:0] & 8'h3D));
                3'd3: fb.push_back(r[7:0] & 8'h3F);
                3'd4: key_read($urandom);
                default: begin
                    fb.push_back(8'hC0 | (r[7:0] & 8'h3F));
                    for (int j = 0; j <= int'(r[10:8] % 5); j++)
                        fb.push_back(8'($urandom));
                end
            endcase
            if (fb.size() != 0) run_frame("rand");
        end

        // Reset in the middle of a key read
        fb = '{8'h8D};
        run_frame("pre_rst_on");
        fb = '{8'h44};
        run_frame("pre_rst_fix");
        i_keys = 32'hFFFF_FFFF;
        lk.i_ledkey_stb = 1'b0;
        #HALF;
        send_byte(8'h42);
        for (int i = 0; i < 10; i++) send_bit(1'b0);
        check("mr_oe_pre", 32'(lk.o_ledkey_dio_oe), 32'd1);
        rst_n = 1'b0;
        #10;
        check("mr_oe", 32'(lk.o_ledkey_dio_oe), 32'd0);
        check("mr_on", 32'(o_display_on), 32'd0);
        check("mr_br", 32'(o_brightness), 32'd0);
        lk.i_ledkey_stb = 1'b1;
        #40;
        rst_n = 1'b1;
        #100;
        m_on = 1'b0;
        m_br = 3'd0;
        m_auto = 1'b1;
        fb = '{8'hCE, 8'h01, 8'h02};
        run_frame("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tm1638_responder.md
Name: tm1638_responder

Overview:
- Device-side (peripheral) end of the LED&KEY serial link: a synthesizable TM1638 responder.
- Oversamples the controller's clock/strobe/data lines on the system clock and decodes command, address and data bytes.
- Emits display-RAM writes and display-control state, and serves key-scan reads by shifting key data back on DIO.
- Used as the LED&KEY model in game benches, and as a board emulator driving an on-chip display.

Parameters:
- SYNC_STAGES, 2: synchronizer depth on i_ledkey_clk / i_ledkey_stb / i_ledkey_dio. Minimum 2.
- AUTO_INC_RESET, 1: reset value of the address auto-increment flag.

Ports:
- i_clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_ledkey_clk  in  1  serial clock from controller (asynchronous to i_clk)
- i_ledkey_stb  in  1  frame strobe, active low
- i_ledkey_dio  in  1  serial data from controller
- o_ledkey_dio  out  1  read data to controller
- o_ledkey_dio_oe  out  1  drive enable for o_ledkey_dio (top level builds the inout)
- i_keys  in  32  key-scan bytes; byte0 = i_keys[7:0], sent first
- o_wr_en  out  1  one-cycle display-RAM write strobe
- o_wr_addr  out  4  display-RAM address
- o_wr_data  out  8  display-RAM data
- o_display_on  out  1  display enable
- o_brightness  out  3  brightness level
- o_frame_err  out  1  one-cycle pulse: frame ended mid-byte

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - Reset is synchronous, active-low on rst_n.
  - Reset values: every output 0; auto_inc = AUTO_INC_RESET; address pointer 0; state IDLE.
- Input synchronization and edge detection:
  - All three inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized copies.
  - The controller's clock high and low phases must each be at least SYNC_STAGES+1 i_clk periods.
- Bit order and timing:
  - Serial bits are LSB first.
  - Input is sampled on rising edges of the synchronized clock.
  - Read data changes on falling edges.
- State machine states: IDLE, CMD, WRITE, READ, IGNORE.
- Strobe falling edge (any state): clear bit counter and shift register; go to CMD.
- Strobe rising edge (any state):
  - Go to IDLE and set o_ledkey_dio_oe = 0.
  - Discard any partial byte.
  - If the bit counter is nonzero, pulse o_frame_err for 1 cycle.
- A byte completes on the 8th rising edge. Decoding is done in the cycle after that edge is detected.
- Decoding in CMD (b = received byte):
  - b[7:6] = 01, b[1] = 1 (0x42, read keys): latch i_keys into a 32-bit shift register; go to READ.
  - b[7:6] = 01, b[1] = 0: auto_inc = ~b[2] (0x40 gives increment, 0x44 gives fixed); go to IGNORE.
  - b[7:6] = 10: o_display_on = b[3], o_brightness = b[2:0]; go to IGNORE.
  - b[7:6] = 11: address pointer = b[3:0]; go to WRITE.
  - b[7:6] = 00: go to IGNORE (no state change).
- WRITE state:
  - Each completed byte pulses o_wr_en for exactly 1 cycle, with o_wr_addr = pointer and o_wr_data = byte.
  - In that same cycle, if auto_inc is set, pointer increments modulo 16 (15 wraps to 0).
  - o_wr_en latency: SYNC_STAGES+1 i_clk cycles after the raw 8th rising edge.
  - o_wr_addr and o_wr_data hold their values between writes.
- READ state:
  - On each synchronized falling edge: o_ledkey_dio_oe = 1, o_ledkey_dio = shift register LSB, then shift right.
  - The first falling edge after the command byte presents i_keys[0].
  - After the 32nd bit, the next falling edge sets oe = 0 and the state goes to IGNORE.
  - Rising edges in READ do not shift the input register.
- IGNORE state: clock edges are counted only for o_frame_err purposes; no other effects.
- Boundaries:
  - Strobe high at any time aborts the frame, including mid-READ; oe drops within 1 cycle of the detected edge.
  - Simultaneous strobe and clock edges in the same cycle: the strobe wins.
  - Display-control and auto_inc state persist across frames.
  - Reset mid-frame returns everything to reset values; the next frame needs a fresh strobe falling edge.

Test Plan:
- Display control: frame 0x8F → o_display_on=1, o_brightness=7; no o_wr_en pulses.
- Auto-increment write: frame 0x40, then frame 0xC0,0x3F,0x06,0x5B → three writes (0,0x3F), (1,0x06), (2,0x5B), each o_wr_en pulse exactly 1 cycle.
- Fixed address with wrap:
  - Frame 0x44, then 0xCF,0xAA,0x55 → two writes, both to address 15.
  - Frame 0x40, then 0xCF,0x11,0x22 → writes (15,0x11), (0,0x22).
- Key read: i_keys=0x80_00_01_A5, frame 0x42 plus 32 clocks → bits captured on controller rising edges = 0xA5,0x01,0x00,0x80 (LSB first); oe low after the 32nd bit and after strobe high.
- Abort: strobe rises after 5 bits of 0xC3 → o_frame_err single pulse; no write; IDLE; the next valid frame decodes correctly.
- Reset: rst_n low mid-READ → o_ledkey_dio_oe=0, o_display_on=0, o_brightness=0 on the next clock; auto_inc back to 1.
